// File: rtl/ddr_inst_pkg.sv
// Shared definitions for the DDR instruction issuer.
// Contents:
//   INST_WIDTH / OPC_WIDTH / IMM_WIDTH  instruction field widths
//   NOP, LDA, LDD, RDP, WRP             controller opcodes
//   state_t                             issuer FSM states
//   make_inst()                         packs an opcode and an immediate into an instruction
package ddr_inst_pkg;

  localparam int INST_WIDTH = 12;
  localparam int OPC_WIDTH  = 4;
  localparam int IMM_WIDTH  = 8;

  localparam logic [OPC_WIDTH-1:0] NOP = 4'd0;  // no operation
  localparam logic [OPC_WIDTH-1:0] LDA = 4'd1;  // shift immediate into address register
  localparam logic [OPC_WIDTH-1:0] LDD = 4'd2;  // shift immediate into data register
  localparam logic [OPC_WIDTH-1:0] RDP = 4'd3;  // read page
  localparam logic [OPC_WIDTH-1:0] WRP = 4'd4;  // write page

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CMD   = 3'd3,
    ST_GUARD = 3'd4,
    ST_WAIT  = 3'd5,
    ST_RESP  = 3'd6
  } state_t;

  function automatic logic [INST_WIDTH-1:0] make_inst(
    input logic [OPC_WIDTH-1:0] opc,
    input logic [IMM_WIDTH-1:0] imm
  );
    return {opc, imm};
  endfunction

endpackage

// File: rtl/ddr_inst_shifter.sv
// Byte serializer for the issuer: loads a word and presents its bytes MSB first.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low
//   i_load     capture i_word and restart at its most significant byte
//   i_word     word to serialize (WIDTH bits, WIDTH a multiple of 8)
//   i_advance  current byte has been consumed; move to the next one
//   o_byte     byte currently presented
//   o_last     the presented byte is the final one of the word
module ddr_inst_shifter #(
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_advance,
  output logic [7:0]       o_byte,
  output logic             o_last
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  logic [WIDTH-1:0] r_word;
  logic [CNT_W-1:0] r_cnt;

  // The word shifts left so the outgoing byte always sits in the top lane.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_cnt  <= '0;
    end else if (i_advance) begin
      r_word <= r_word << 8;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign o_byte = r_word[WIDTH-1 -: 8];
  assign o_last = (r_cnt == LAST_IDX);

endmodule

// File: rtl/ddr_inst_issuer.sv
// Hardware initiator for the DDR controller instruction port. Takes one page
// read/write request at a time, serializes it into LDA/LDD/RDP/WRP
// instructions, waits for the controller and returns the captured page.
//
// Optional build macro: DDRISSUE_TIMEOUT_EN adds a watchdog on the wait for
// the controller; on expiry the response carries rsp_err = 1 and zero data.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready      host request handshake
//   req_write/addr/data      request contents (data ignored on reads)
//   rsp_valid/data/err       one-cycle completion strobe with page and timeout flag
//   inst/inst_en             instruction to the controller and its strobe
//   ctl_page/ctl_ready       controller page output and idle/accepting flag
//   busy                     high whenever the FSM is not in IDLE
//   dbg_state                current FSM state (state_t encoding)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is registered and is high only while
// the FSM sits in IDLE (and not on the first cycle after reset release);
// req_valid during busy cycles is ignored. rsp_valid is a single-cycle
// strobe with no backpressure.
module ddr_inst_issuer
  import ddr_inst_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_en,
  input  logic [31:0]           ctl_page,
  input  logic                  ctl_ready,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  if ((ADDR_WIDTH < 8) || ((ADDR_WIDTH % 8) != 0)) begin : g_bad_addr_width
    $error("ADDR_WIDTH must be a positive multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t          r_state;
  state_t          w_next;
  logic            r_req_ready;
  logic            r_write;
  logic [31:0]     r_rsp_data;
  logic            w_accept;
  logic            w_addr_adv;
  logic            w_data_adv;
  logic [7:0]      w_addr_byte;
  logic [7:0]      w_data_byte;
  logic            w_addr_last;
  logic            w_data_last;
  logic            w_capture;
  logic            w_timeout;
  logic [INST_WIDTH-1:0] w_inst;

  assign w_accept   = req_valid & r_req_ready;
  assign w_addr_adv = (r_state == ST_ADDR) & ctl_ready;
  assign w_data_adv = (r_state == ST_DATA) & ctl_ready;
  assign w_capture  = (r_state == ST_WAIT) & ctl_ready;

  ddr_inst_shifter #(.WIDTH(ADDR_WIDTH)) u_addr_shifter (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_accept),
    .i_word    (req_addr),
    .i_advance (w_addr_adv),
    .o_byte    (w_addr_byte),
    .o_last    (w_addr_last)
  );

  ddr_inst_shifter #(.WIDTH(32)) u_data_shifter (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_accept),
    .i_word    (req_data),
    .i_advance (w_data_adv),
    .o_byte    (w_data_byte),
    .o_last    (w_data_last)
  );

`ifdef DDRISSUE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_rsp_err;

  // r_to_cnt counts completed WAIT cycles; the limit is hit on the
  // TIMEOUT_CYCLES-th WAIT cycle. A ready on that same cycle wins.
  assign w_timeout = (r_state == ST_WAIT) & ~ctl_ready &
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to_cnt  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == ST_GUARD) begin
        r_to_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_timeout) begin
        r_rsp_err <= 1'b1;
      end else if (w_capture) begin
        r_rsp_err <= 1'b0;
      end
    end
  end

  assign rsp_err = r_rsp_err & (r_state == ST_RESP);
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ADDR;
      ST_ADDR:  if (ctl_ready && w_addr_last) w_next = r_write ? ST_DATA : ST_CMD;
      ST_DATA:  if (ctl_ready && w_data_last) w_next = ST_CMD;
      ST_CMD:   if (ctl_ready) w_next = ST_GUARD;
      // The controller drops ready the cycle after a command, so this
      // cycle is spent without looking at ctl_ready.
      ST_GUARD: w_next = ST_WAIT;
      ST_WAIT:  if (ctl_ready || w_timeout) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_next;
      // Registered so it stays low on the first cycle after reset release.
      r_req_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_write <= req_write;
      end
      if (w_capture) begin
        r_rsp_data <= ctl_page;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
      end
    end
  end

  // inst is decoded from the registered state and shifter contents, so it
  // naturally holds while ctl_ready stalls the shifters.
  always_comb begin
    w_inst = make_inst(NOP, 8'h00);
    case (r_state)
      ST_ADDR: w_inst = make_inst(LDA, w_addr_byte);
      ST_DATA: w_inst = make_inst(LDD, w_data_byte);
      ST_CMD:  w_inst = make_inst(r_write ? WRP : RDP, 8'h00);
      default: w_inst = make_inst(NOP, 8'h00);
    endcase
  end

  // Combinational from the asynchronously reset state, so a reset drops
  // the strobe immediately.
  assign inst_en = ((r_state == ST_ADDR) || (r_state == ST_DATA) ||
                    (r_state == ST_CMD)) & ctl_ready;

  assign inst      = w_inst;
  assign req_ready = r_req_ready;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ddr_inst_issuer.sv
// Self-checking bench for ddr_inst_issuer. A controller model drives
// ctl_ready/ctl_page; expected instruction streams, response timing and
// response data are computed from the request contents and the model's
// own ready decisions.
module tb_ddr_inst_issuer;
  import ddr_inst_pkg::*;

  localparam int AW = 24;
  localparam int AB = AW / 8;
  localparam int TO = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [31:0]   req_data  = '0;
  logic [31:0]   ctl_page  = '0;
  logic          ctl_ready = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic [11:0]   inst;
  logic          inst_en;
  logic          busy;
  logic [2:0]    dbg_state;

  int checks = 0;
  int passed = 0;

  // scoreboard
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  ddr_inst_issuer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .inst      (inst),
    .inst_en   (inst_en),
    .ctl_page  (ctl_page),
    .ctl_ready (ctl_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full transaction. stall_mode: 0 none, 1 random, 2 hold ready low
  // for stall_len cycles when instruction number stall_idx is due.
  // After the command the controller keeps ready low for wait_lo cycles.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                         input logic [31:0] data, input int stall_mode,
                         input int stall_idx, input int stall_len,
                         input int wait_lo, input logic [31:0] page,
                         input string name);
    int n_inst, k_cap, cmd_t, rsp_t, rsp_cnt, issued, stalls, stall_done;
    int hold_err, en_err, busy_err, acc_wait;
    logic cmd_seen, rdy, exp_err, rsp_e, post_rdy, post_busy, post_rv;
    logic [31:0] exp_data, rsp_d;

    exp_q.delete();
    obs_q.delete();
    for (int b = AB - 1; b >= 0; b--) exp_q.push_back({LDA, addr[b*8 +: 8]});
    if (wr) for (int b = 3; b >= 0; b--) exp_q.push_back({LDD, data[b*8 +: 8]});
    exp_q.push_back({(wr ? WRP : RDP), 8'h00});
    n_inst = exp_q.size();
    // Cycle (counted from the command cycle) in which the page is taken:
    // the guard cycle is k=1, the wait starts at k=2.
    k_cap    = (wait_lo + 1 > 2) ? wait_lo + 1 : 2;
    exp_err  = 1'b0;
    exp_data = page;
`ifdef DDRISSUE_TIMEOUT_EN
    if (k_cap > TO + 1) begin
      k_cap    = TO + 1;
      exp_err  = 1'b1;
      exp_data = '0;
    end
`endif

    @(negedge clock);
    ctl_ready = 1'b1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_data  = data;
    acc_wait  = 0;
    #1;
    while (!req_ready && acc_wait < 50) begin
      @(negedge clock);
      #1;
      acc_wait++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL %s accept: req_ready got %b expected 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end else passed++;

    @(posedge clock);
    #1;
    // Junk on the request port while busy must have no effect.
    req_addr  = AW'($urandom);
    req_data  = $urandom;
    req_write = 1'($urandom_range(0, 1));

    cmd_seen = 0; cmd_t = -1; rsp_t = -1; rsp_cnt = 0; issued = 0;
    stalls = 0; stall_done = 0; hold_err = 0; en_err = 0; busy_err = 0;
    rsp_d = '0; rsp_e = 1'b0; post_rdy = 1'b0; post_busy = 1'b1; post_rv = 1'b1;

    for (int t = 1; t <= 200; t++) begin
      @(negedge clock);
      if (!cmd_seen) begin
        case (stall_mode)
          1:       rdy = ($urandom_range(0, 3) != 0);
          2:       rdy = !(issued == stall_idx && stall_done < stall_len);
          default: rdy = 1'b1;
        endcase
        if (!rdy) begin
          stalls++;
          if (stall_mode == 2) stall_done++;
        end
        ctl_page = $urandom;
      end else begin
        rdy      = (t - cmd_t) > wait_lo;
        ctl_page = ((t - cmd_t) == k_cap) ? page : ~page;
      end
      ctl_ready = rdy;
      #1;
      if (rsp_t > 0 && t == rsp_t + 1) begin
        post_rdy  = req_ready;
        post_busy = busy;
        post_rv   = rsp_valid;
        break;
      end
      if (busy !== 1'b1 || req_ready !== 1'b0) busy_err++;
      if (!cmd_seen && !rdy && issued < n_inst && inst !== exp_q[issued]) hold_err++;
      if (inst_en === 1'b1) begin
        obs_q.push_back(inst);
        if (!rdy || cmd_seen) en_err++;
        issued++;
        if (issued == n_inst) begin
          cmd_seen = 1'b1;
          cmd_t    = t;
        end
      end
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        if (rsp_cnt == 1) begin
          rsp_t = t;
          rsp_d = rsp_data;
          rsp_e = rsp_err;
        end
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    ctl_ready = 1'b1;

    checks++;
    if (obs_q.size() !== n_inst)
      $display("FAIL %s inst_count: got %0d expected %0d", name, obs_q.size(), n_inst);
    else passed++;
    for (int i = 0; i < n_inst; i++) begin
      checks++;
      if (i >= obs_q.size())
        $display("FAIL %s inst[%0d]: got none expected %h", name, i, exp_q[i]);
      else if (obs_q[i] !== exp_q[i])
        $display("FAIL %s inst[%0d]: got %h expected %h", name, i, obs_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (hold_err !== 0) $display("FAIL %s inst_hold: got %0d bad cycles expected 0", name, hold_err);
    else passed++;
    checks++;
    if (en_err !== 0) $display("FAIL %s inst_en_rule: got %0d bad cycles expected 0", name, en_err);
    else passed++;
    checks++;
    if (busy_err !== 0) $display("FAIL %s busy_ready: got %0d bad cycles expected 0", name, busy_err);
    else passed++;
    checks++;
    if (cmd_t !== n_inst + stalls)
      $display("FAIL %s cmd_cycle: got %0d expected %0d", name, cmd_t, n_inst + stalls);
    else passed++;
    checks++;
    if (rsp_cnt !== 1) $display("FAIL %s rsp_count: got %0d expected 1", name, rsp_cnt);
    else passed++;
    checks++;
    if (rsp_t !== cmd_t + k_cap + 1)
      $display("FAIL %s rsp_cycle: got %0d expected %0d", name, rsp_t, cmd_t + k_cap + 1);
    else passed++;
    checks++;
    if (rsp_d !== exp_data) $display("FAIL %s rsp_data: got %h expected %h", name, rsp_d, exp_data);
    else passed++;
    checks++;
    if (rsp_e !== exp_err) $display("FAIL %s rsp_err: got %b expected %b", name, rsp_e, exp_err);
    else passed++;
    checks++;
    if (post_rdy !== 1'b1 || post_busy !== 1'b0 || post_rv !== 1'b0)
      $display("FAIL %s after_resp: got ready=%b busy=%b rsp_valid=%b expected 1 0 0",
               name, post_rdy, post_busy, post_rv);
    else passed++;
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'hABCDEF;
    req_data  = 32'h1234_5678;
    ctl_ready = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        inst_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_flags: got ready=%b rsp_valid=%b rsp_err=%b inst_en=%b busy=%b expected all 0",
               req_ready, rsp_valid, rsp_err, inst_en, busy);
    else passed++;
    checks++;
    if (inst !== 12'h000 || rsp_data !== 32'h0)
      $display("FAIL reset_values: got inst=%h rsp_data=%h expected 000 00000000", inst, rsp_data);
    else passed++;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) $display("FAIL release_ready: got %b expected 0", req_ready);
    else passed++;
    @(posedge clock);
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL first_edge: got ready=%b busy=%b expected 1 0", req_ready, busy);
    else passed++;
    req_valid = 1'b0;
  endtask

  task automatic test_read_basic();
    run_txn(1'b0, 24'h12_34_56, 32'h0, 0, 0, 0, 0, 32'hDEAD_BEEF, "read_min_latency");
    run_txn(1'b0, 24'h12_34_56, 32'h0, 0, 0, 0, 5, 32'hDEAD_BEEF, "read_wait5");
  endtask

  task automatic test_write_basic();
    run_txn(1'b1, 24'h00_00_01, 32'hA5A5_0F0F, 0, 0, 0, 0, 32'h0BAD_F00D, "write_basic");
  endtask

  task automatic test_stall();
    run_txn(1'b0, 24'hC3_5A_7E, 32'h0, 2, 1, 3, 0, 32'h1357_9BDF, "stall_2nd_lda");
    run_txn(1'b1, 24'h01_02_03, 32'hF00D_CAFE, 2, 5, 2, 1, 32'h2468_ACE0, "stall_ldd");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 1, 0, 0,
              $urandom_range(0, 6), $urandom, "random");
  endtask

  task automatic test_reset_mid();
    int   stale;
    logic found;
    // Abort while instructions are being issued.
    @(negedge clock);
    ctl_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 24'h55_66_77;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(negedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    #2;
    checks++;
    if (inst_en !== 1'b1) $display("FAIL abort_pre: inst_en got %b expected 1", inst_en);
    else passed++;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (inst_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_issue: got inst_en=%b busy=%b expected 0 0", inst_en, busy);
    else passed++;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Abort while waiting for the controller.
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 24'h9A_BC_DE;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      if (inst_en === 1'b1 && inst[11:8] === RDP) begin
        found = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (found !== 1'b1) $display("FAIL abort_cmd_seen: got %b expected 1", found);
    else passed++;
    @(posedge clock);
    #1 ctl_ready = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL abort_wait: got busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    else passed++;
    ctl_ready = 1'b1;
    ctl_page  = 32'hFFFF_0000;
    stale = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      #1;
      if (rsp_valid !== 1'b0) stale++;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) $display("FAIL abort_stale: got %0d stale cycles expected 0", stale);
    else passed++;
    run_txn(1'b0, 24'h0F_1E_2D, 32'h0, 0, 0, 0, 2, 32'h7654_3210, "after_abort");
  endtask

  task automatic test_timeout();
    // Ready never returns: bounded by the watchdog when enabled.
    run_txn(1'b0, 24'h44_33_22, 32'h0, 0, 0, 0, 100, 32'h8888_7777, "ready_stuck");
    // Ready returns exactly on the watchdog limit cycle.
    run_txn(1'b1, 24'h11_22_33, 32'hCAFE_BABE, 0, 0, 0, TO, 32'h3C3C_5A5A, "ready_at_limit");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 24'hFF_FF_FF, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF, "b2b_ones");
    run_txn(1'b0, 24'h00_00_00, 32'h0, 0, 0, 0, 0, 32'h0000_0000, "b2b_zeros");
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
